// File: rtl/and_cascade_pkg.sv
// Shared definitions for the AND-reduction response checker: FSM encoding and
// parameter defaults used by the checker and its delay line.
package and_cascade_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

endpackage

// File: rtl/valid_delay_line.sv
// Depth-LATENCY shift register of {valid, expected, data} with a synchronous
// flush of all valid bits; a plain pass-through when LATENCY is 0.
module valid_delay_line #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             exp_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             exp_o
);

  if (LATENCY == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, flush_i};
    assign valid_o   = valid_i;
    assign data_o    = data_i;
    assign exp_o     = exp_i;
  end else begin : g_pipe
    logic [LATENCY-1:0] vld_q;
    logic [WIDTH:0]     pay_q [LATENCY];

    // NOTE: registered state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the shift stays ordered.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else if (flush_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= valid_i;
        for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    // NOTE: the payload array is deliberately left without reset; an entry
    // is only ever consumed when its valid bit is set, so this stays plain
    // storage with no reset fan-out.
    always_ff @(posedge clk) begin
      pay_q[0] <= {exp_i, data_i};
      for (int i = 1; i < LATENCY; i++) pay_q[i] <= pay_q[i-1];
    end

    assign valid_o         = vld_q[LATENCY-1];
    assign {exp_o, data_o} = pay_q[LATENCY-1];
  end

endmodule

// File: rtl/and_cascade_checker.sv
// Response monitor for the AND reduction: aligns the reference result to the
// datapath latency, compares, counts, and captures the first failure.
module and_cascade_checker
  import and_cascade_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = 0,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             dut_out,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             error,
  output logic [WIDTH-1:0] first_err_data,
  output logic             first_err_got,
  output logic [1:0]       state
);

  logic             dl_valid;
  logic [WIDTH-1:0] dl_data;
  logic             dl_exp;
  logic             strobe;
  logic             mismatch;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] first_data_q, first_data_d;
  logic             first_got_q, first_got_d;
  state_e           state_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Samples arriving together with clear are flushed along with the pipeline.
  valid_delay_line #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(clear),
    .valid_i(sample_valid),
    .data_i (sample_in),
    .exp_i  (&sample_in),
    .valid_o(dl_valid),
    .data_o (dl_data),
    .exp_o  (dl_exp)
  );

  assign strobe   = dl_valid && !clear;
  assign mismatch = strobe && (dut_out != dl_exp);

  // NOTE: every variable gets its hold value first so no path through this
  // block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    err_cnt_d    = err_cnt_q;
    error_d      = error_q;
    first_data_d = first_data_q;
    first_got_d  = first_got_q;
    if (strobe) begin
      sample_cnt_d = sat_inc(sample_cnt_q);
      if (dl_exp) hit_cnt_d = sat_inc(hit_cnt_q);
      if (mismatch) begin
        err_cnt_d = sat_inc(err_cnt_q);
        if (!error_q) begin
          error_d      = 1'b1;
          first_data_d = dl_data;
          first_got_d  = dut_out;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      hit_cnt_q    <= '0;
      err_cnt_q    <= '0;
      error_q      <= 1'b0;
      first_data_q <= '0;
      first_got_q  <= 1'b0;
      state_q      <= ST_IDLE;
    end else if (clear) begin
      sample_cnt_q <= '0;
      hit_cnt_q    <= '0;
      err_cnt_q    <= '0;
      error_q      <= 1'b0;
      first_data_q <= '0;
      first_got_q  <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      err_cnt_q    <= err_cnt_d;
      error_q      <= error_d;
      first_data_q <= first_data_d;
      first_got_q  <= first_got_d;
      if (strobe) begin
        case (state_q)
          ST_IDLE: state_q <= mismatch ? ST_FAIL : ST_RUN;
          ST_RUN:  if (mismatch) state_q <= ST_FAIL;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign sample_cnt     = sample_cnt_q;
  assign hit_cnt        = hit_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign error          = error_q;
  assign first_err_data = first_data_q;
  assign first_err_got  = first_got_q;
  assign state          = state_q;

endmodule

// File: tb/tb_and_cascade_checker.sv
// Bench for and_cascade_checker: three configurations driven by directed and
// random steps, each compared against a queue-based scoreboard of the rules.
module tb_and_cascade_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_clr [3];
  logic       in_v   [3];
  logic [7:0] in_d   [3];
  logic       in_o   [3];

  logic [15:0] l0_sc, l0_hc, l0_ec;
  logic        l0_er, l0_fg;
  logic [7:0]  l0_fd;
  logic [1:0]  l0_st;
  logic [15:0] l3_sc, l3_hc, l3_ec;
  logic        l3_er, l3_fg;
  logic [7:0]  l3_fd;
  logic [1:0]  l3_st;
  logic [3:0]  c4_sc, c4_hc, c4_ec;
  logic        c4_er, c4_fg;
  logic [7:0]  c4_fd;
  logic [1:0]  c4_st;

  always #5 clk = ~clk;

  and_cascade_checker #(.WIDTH(8), .LATENCY(0), .CNT_W(16)) u_l0 (
    .clk(clk), .rst_n(rst_n), .clear(in_clr[0]), .sample_valid(in_v[0]),
    .sample_in(in_d[0]), .dut_out(in_o[0]), .sample_cnt(l0_sc), .hit_cnt(l0_hc),
    .err_cnt(l0_ec), .error(l0_er), .first_err_data(l0_fd),
    .first_err_got(l0_fg), .state(l0_st));

  and_cascade_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) u_l3 (
    .clk(clk), .rst_n(rst_n), .clear(in_clr[1]), .sample_valid(in_v[1]),
    .sample_in(in_d[1]), .dut_out(in_o[1]), .sample_cnt(l3_sc), .hit_cnt(l3_hc),
    .err_cnt(l3_ec), .error(l3_er), .first_err_data(l3_fd),
    .first_err_got(l3_fg), .state(l3_st));

  and_cascade_checker #(.WIDTH(8), .LATENCY(2), .CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .clear(in_clr[2]), .sample_valid(in_v[2]),
    .sample_in(in_d[2]), .dut_out(in_o[2]), .sample_cnt(c4_sc), .hit_cnt(c4_hc),
    .err_cnt(c4_ec), .error(c4_er), .first_err_data(c4_fd),
    .first_err_got(c4_fg), .state(c4_st));

  // Scoreboard: pending samples carry the cycle at which they must be compared.
  typedef struct {
    int       due;
    bit [7:0] data;
  } pend_t;

  pend_t    pq [3][$];
  int       lat  [3] = '{0, 3, 2};
  int       cmax [3] = '{65535, 65535, 15};
  int       m_sc [3];
  int       m_hc [3];
  int       m_ec [3];
  bit       m_er [3];
  bit [7:0] m_fd [3];
  bit       m_fg [3];
  int       m_st [3];
  bit [7:0] hist [3][64];
  int       cyc_n    = 0;
  int       n_checks = 0;
  int       n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Correct reduction output for instance k if the block had latency s.
  function automatic bit ref_out(input int k, input int s);
    bit [7:0] d;
    d = (s == 0) ? in_d[k] : hist[k][(cyc_n - s) & 63];
    return &d;
  endfunction

  task automatic model_clear(input int k);
    m_sc[k] = 0; m_hc[k] = 0; m_ec[k] = 0;
    m_er[k] = 1'b0; m_fd[k] = 8'h00; m_fg[k] = 1'b0; m_st[k] = 0;
    pq[k].delete();
  endtask

  task automatic model_compare(input int k, input bit [7:0] d, input bit o);
    bit e;
    bit mm;
    e  = (d == 8'hFF);
    mm = (o != e);
    if (m_sc[k] < cmax[k]) m_sc[k]++;
    if (e && m_hc[k] < cmax[k]) m_hc[k]++;
    if (mm) begin
      if (m_ec[k] < cmax[k]) m_ec[k]++;
      if (!m_er[k]) begin
        m_er[k] = 1'b1;
        m_fd[k] = d;
        m_fg[k] = o;
      end
      m_st[k] = 2;
    end else if (m_st[k] == 0) begin
      m_st[k] = 1;
    end
  endtask

  task automatic model_edge(input int k);
    pend_t p;
    if (in_clr[k]) begin
      model_clear(k);
      return;
    end
    if (lat[k] == 0) begin
      if (in_v[k]) model_compare(k, in_d[k], in_o[k]);
    end else begin
      if (pq[k].size() > 0 && pq[k][0].due == cyc_n) begin
        model_compare(k, pq[k][0].data, in_o[k]);
        void'(pq[k].pop_front());
      end
      if (in_v[k]) begin
        p.due  = cyc_n + lat[k];
        p.data = in_d[k];
        pq[k].push_back(p);
      end
    end
  endtask

  task automatic edge_all();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      model_edge(k);
      hist[k][cyc_n & 63] = in_d[k];
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic cyc(input int k, input bit clr, input bit v, input bit [7:0] d, input bit o);
    for (int j = 0; j < 3; j++) begin
      in_clr[j] = 1'b0; in_v[j] = 1'b0; in_d[j] = 8'h00; in_o[j] = 1'b0;
    end
    in_clr[k] = clr; in_v[k] = v; in_d[k] = d; in_o[k] = o;
    edge_all();
  endtask

  task automatic check_inst(input int k, input string tag);
    logic [31:0] o_sc, o_hc, o_ec, o_fd;
    logic        o_er, o_fg;
    logic [1:0]  o_st;
    case (k)
      0: begin
        o_sc = 32'(l0_sc); o_hc = 32'(l0_hc); o_ec = 32'(l0_ec);
        o_er = l0_er; o_fd = 32'(l0_fd); o_fg = l0_fg; o_st = l0_st;
      end
      1: begin
        o_sc = 32'(l3_sc); o_hc = 32'(l3_hc); o_ec = 32'(l3_ec);
        o_er = l3_er; o_fd = 32'(l3_fd); o_fg = l3_fg; o_st = l3_st;
      end
      default: begin
        o_sc = 32'(c4_sc); o_hc = 32'(c4_hc); o_ec = 32'(c4_ec);
        o_er = c4_er; o_fd = 32'(c4_fd); o_fg = c4_fg; o_st = c4_st;
      end
    endcase
    chk($sformatf("%s/i%0d/sample_cnt", tag, k), o_sc, 32'(m_sc[k]));
    chk($sformatf("%s/i%0d/hit_cnt", tag, k), o_hc, 32'(m_hc[k]));
    chk($sformatf("%s/i%0d/err_cnt", tag, k), o_ec, 32'(m_ec[k]));
    chk($sformatf("%s/i%0d/error", tag, k), 32'(o_er), 32'(m_er[k]));
    chk($sformatf("%s/i%0d/first_err_data", tag, k), o_fd, 32'(m_fd[k]));
    chk($sformatf("%s/i%0d/first_err_got", tag, k), 32'(o_fg), 32'(m_fg[k]));
    chk($sformatf("%s/i%0d/state", tag, k), 32'(o_st), 32'(m_st[k]));
  endtask

  initial begin
    bit [7:0] d;

    // Reset
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_clr[j] = 1'b0; in_v[j] = 1'b0; in_d[j] = 8'h00; in_o[j] = 1'b0;
      model_clear(j);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) check_inst(k, "reset");

    // Full sweep, LATENCY=0, correct responses
    for (int i = 0; i < 256; i++) begin
      d = 8'(i);
      cyc(0, 1'b0, 1'b1, d, &d);
    end
    check_inst(0, "sweep");
    chk("sweep/sample_cnt", 32'(l0_sc), 32'd256);
    chk("sweep/hit_cnt", 32'(l0_hc), 32'd1);
    chk("sweep/err_cnt", 32'(l0_ec), 32'd0);
    chk("sweep/state", 32'(l0_st), 32'd1);
    chk("sweep/error", 32'(l0_er), 32'd0);

    // LATENCY=3, correctly delayed responses
    cyc(1, 1'b0, 1'b1, 8'hFF, ref_out(1, 3));
    cyc(1, 1'b0, 1'b1, 8'h7F, ref_out(1, 3));
    repeat (3) cyc(1, 1'b0, 1'b0, 8'h00, ref_out(1, 3));
    check_inst(1, "lat3");
    chk("lat3/hit_cnt", 32'(l3_hc), 32'd1);
    chk("lat3/error", 32'(l3_er), 32'd0);

    // Responses skewed to two cycles
    cyc(1, 1'b0, 1'b1, 8'hFF, ref_out(1, 2));
    cyc(1, 1'b0, 1'b1, 8'h7F, ref_out(1, 2));
    repeat (3) cyc(1, 1'b0, 1'b0, 8'h00, ref_out(1, 2));
    check_inst(1, "skew");
    chk("skew/error", 32'(l3_er), 32'd1);
    chk("skew/first_err_data", 32'(l3_fd), 32'hFF);
    chk("skew/first_err_got", 32'(l3_fg), 32'd0);

    // Two injected errors; only the first is captured
    cyc(0, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(0, 1'b0, 1'b1, 8'h0F, 1'b1);
    cyc(0, 1'b0, 1'b1, 8'hFF, 1'b0);
    check_inst(0, "inject");
    chk("inject/err_cnt", 32'(l0_ec), 32'd2);
    chk("inject/first_err_data", 32'(l0_fd), 32'h0F);
    chk("inject/first_err_got", 32'(l0_fg), 32'd1);
    chk("inject/state", 32'(l0_st), 32'd2);

    // Clear coinciding with a mismatching strobe, LATENCY=0
    cyc(0, 1'b1, 1'b1, 8'h00, 1'b1);
    check_inst(0, "clr0");
    chk("clr0/sample_cnt", 32'(l0_sc), 32'd0);
    chk("clr0/error", 32'(l0_er), 32'd0);
    chk("clr0/state", 32'(l0_st), 32'd0);
    cyc(0, 1'b0, 1'b1, 8'h33, 1'b0);
    chk("clr0_next/sample_cnt", 32'(l0_sc), 32'd1);
    chk("clr0_next/state", 32'(l0_st), 32'd1);

    // Clear coinciding with a mismatching strobe, LATENCY=3
    cyc(1, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b1, 8'hA5, 1'b0);
    repeat (2) cyc(1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b1, 1'b0, 8'h00, 1'b1);
    repeat (3) cyc(1, 1'b0, 1'b0, 8'h00, 1'b1);
    check_inst(1, "clr3");
    chk("clr3/sample_cnt", 32'(l3_sc), 32'd0);
    chk("clr3/state", 32'(l3_st), 32'd0);

    // Saturation with CNT_W=4
    repeat (20) cyc(2, 1'b0, 1'b1, 8'hFF, ref_out(2, 2));
    repeat (2) cyc(2, 1'b0, 1'b0, 8'h00, ref_out(2, 2));
    check_inst(2, "sat");
    chk("sat/sample_cnt", 32'(c4_sc), 32'd15);
    chk("sat/hit_cnt", 32'(c4_hc), 32'd15);
    chk("sat/err_cnt", 32'(c4_ec), 32'd0);

    // Asynchronous reset with samples in flight
    cyc(2, 1'b0, 1'b1, 8'hFF, ref_out(2, 2));
    cyc(2, 1'b0, 1'b1, 8'h01, ref_out(2, 2));
    #2 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) model_clear(k);
    #1;
    for (int k = 0; k < 3; k++) check_inst(k, "async_rst");
    chk("async_rst/sample_cnt", 32'(c4_sc), 32'd0);
    chk("async_rst/state", 32'(c4_st), 32'd0);
    #1 rst_n = 1'b1;
    repeat (4) cyc(2, 1'b0, 1'b0, 8'h00, 1'b1);
    check_inst(2, "post_rst");
    chk("post_rst/sample_cnt", 32'(c4_sc), 32'd0);
    chk("post_rst/err_cnt", 32'(c4_ec), 32'd0);

    // Random traffic on all instances: gaps, occasional clears and bad responses
    repeat (400) begin
      for (int k = 0; k < 3; k++) begin
        in_clr[k] = ($urandom_range(15) == 0);
        in_v[k]   = ($urandom_range(3) != 0);
        in_d[k]   = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
        in_o[k]   = ($urandom_range(7) == 0) ? 1'($urandom) : ref_out(k, lat[k]);
      end
      edge_all();
      for (int k = 0; k < 3; k++) check_inst(k, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
